// File: rtl/cpu_pkg.sv
// Shared decode definitions for the CPU pipeline slices: opcodes, the
// IF/ID reset instruction, the ID/EX bundle and read-port usage.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SRA  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Loaded into IF/ID on reset/flush; only ever decoded with valid=0.
    localparam logic [15:0] NOP_INSTR = 16'hF000;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic call;
        logic ret;
        logic halt;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc_inc;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [2:0]  cond;
        ctrl_t       ctrl;
    } idex_t;

    // Bit 0: opcode really consumes read port 1; bit 1: read port 2.
    // Used by the load-use detector so unused ports never cause a stall.
    function automatic logic [1:0] read_port_usage(input logic [3:0] op);
        logic [1:0] use_ports;
        use_ports = 2'b00;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW: use_ports = 2'b11;
            OP_SLL, OP_SRL, OP_SRA, OP_ADDI, OP_LW,
            OP_LHB, OP_LLB, OP_RET:               use_ports = 2'b01;
            default:                              use_ports = 2'b00;
        endcase
        return use_ports;
    endfunction

endpackage

// File: rtl/id_slice_if.sv
// Bus between the decode slice and its neighbours: fetch inputs, writeback
// port, fetch stall and the registered ID/EX bundle.
interface id_slice_if;
    logic [15:0] PC_inc;
    logic [15:0] instr;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [15:0] ex_pc_inc;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd;
    logic [3:0]  ex_src1;
    logic [3:0]  ex_src2;
    logic [15:0] ex_rs_data;
    logic [15:0] ex_rt_data;
    logic [15:0] ex_imm;
    logic [2:0]  ex_cond;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_call;
    logic        ex_ret;
    logic        ex_halt;

    modport master (
        output PC_inc, instr, flush, wb_en, wb_addr, wb_data,
        input  stall, ex_valid, ex_pc_inc, ex_op, ex_rd, ex_src1, ex_src2,
               ex_rs_data, ex_rt_data, ex_imm, ex_cond, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_branch, ex_call, ex_ret, ex_halt
    );

    modport slave (
        input  PC_inc, instr, flush, wb_en, wb_addr, wb_data,
        output stall, ex_valid, ex_pc_inc, ex_op, ex_rd, ex_src1, ex_src2,
               ex_rs_data, ex_rt_data, ex_imm, ex_cond, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_branch, ex_call, ex_ret, ex_halt
    );
endinterface

// File: rtl/regfile16.sv
// 16 x 16-bit register file: R0 hardwired to zero, two combinational read
// ports with write-through from the writeback port, synchronous reset.
module regfile16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  raddr1,
    output logic [15:0] rdata1,
    input  logic [3:0]  raddr2,
    output logic [15:0] rdata2,
    input  logic        wen,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] mem [16];

    // Clear everything on reset; otherwise commit writeback, ignoring R0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && (waddr != 4'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: R0 reads zero, a same-cycle write to the address wins.
    always_comb begin
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        if (raddr1 == 4'd0) begin
            rdata1 = '0;
        end else if (wen && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == 4'd0) begin
            rdata2 = '0;
        end else if (wen && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_slice.sv
// Instruction-decode stage: IF/ID register, decoder, register file read,
// load-use / halt stall generation and the registered ID/EX bundle.
module id_slice #(
    parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic    clk,
    input  logic    rst,
    id_slice_if.slave bus
);
    import cpu_pkg::*;

    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    idex_t       idex;
    idex_t       dec;

    logic [3:0]  op;
    logic [3:0]  rd_field;
    logic [3:0]  rs_field;
    logic [3:0]  rt_field;
    logic [3:0]  raddr1;
    logic [3:0]  raddr2;
    logic [15:0] rdata1;
    logic [15:0] rdata2;
    logic [1:0]  ports;
    logic        load_use;
    logic        stall;

    assign op       = ifid_instr[15:12];
    assign rd_field = ifid_instr[11:8];
    assign rs_field = ifid_instr[7:4];
    assign rt_field = ifid_instr[3:0];

    // Read-port address selection: LHB/LLB read rd, RET reads R15, SW
    // stores rd through port 2.
    always_comb begin
        raddr1 = rs_field;
        raddr2 = rt_field;
        if ((op == OP_LHB) || (op == OP_LLB)) begin
            raddr1 = rd_field;
        end else if (op == OP_RET) begin
            raddr1 = 4'hF;
        end
        if (op == OP_SW) begin
            raddr2 = rd_field;
        end
    end

    regfile16 u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .wen    (bus.wb_en),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data)
    );

    // Load-use hazard and stall: flush always overrides, halt is sticky.
    always_comb begin
        ports    = read_port_usage(op);
        load_use = idex.valid && (idex.op == OP_LW) && (idex.rd != 4'd0) && ifid_valid &&
                   ((ports[0] && (raddr1 == idex.rd)) || (ports[1] && (raddr2 == idex.rd)));
        stall    = !bus.flush && (halted || load_use);
    end

    // Decoder: an invalid IF/ID entry produces an all-zero bubble.
    always_comb begin
        dec = '0;
        if (ifid_valid) begin
            dec.valid   = 1'b1;
            dec.pc_inc  = ifid_pc;
            dec.op      = op;
            dec.rd      = (op == OP_CALL) ? 4'hF : rd_field;
            dec.src1    = raddr1;
            dec.src2    = raddr2;
            dec.rs_data = rdata1;
            dec.rt_data = rdata2;
            dec.cond    = ifid_instr[11:9];
            case (op)
                OP_ADDI, OP_LW, OP_SW:  dec.imm = {{12{ifid_instr[3]}}, ifid_instr[3:0]};
                OP_SLL, OP_SRL, OP_SRA: dec.imm = {12'b0, ifid_instr[3:0]};
                OP_LHB, OP_LLB:         dec.imm = {8'b0, ifid_instr[7:0]};
                OP_B:                   dec.imm = {{7{ifid_instr[8]}}, ifid_instr[8:0]};
                OP_CALL:                dec.imm = {{4{ifid_instr[11]}}, ifid_instr[11:0]};
                default:                dec.imm = '0;
            endcase
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SRA, OP_ADDI,
                OP_LW, OP_LHB, OP_LLB, OP_CALL: dec.ctrl.reg_write = (dec.rd != 4'd0);
                default:                        dec.ctrl.reg_write = 1'b0;
            endcase
            dec.ctrl.mem_read  = (op == OP_LW);
            dec.ctrl.mem_write = (op == OP_SW);
            dec.ctrl.branch    = (op == OP_B);
            dec.ctrl.call      = (op == OP_CALL);
            dec.ctrl.ret       = (op == OP_RET);
            dec.ctrl.halt      = (op == OP_HLT);
        end
    end

    // IF/ID register: squashed on reset/flush, held while stalled.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= bus.instr;
            ifid_pc    <= bus.PC_inc;
            ifid_valid <= 1'b1;
        end
    end

    // ID/EX register: bubble on reset, flush or stall, else the decode.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || stall) begin
            idex <= '0;
        end else begin
            idex <= dec;
        end
    end

    // Sticky halt flag, set when a real HLT moves into ID/EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (!bus.flush && !stall && dec.valid && dec.ctrl.halt) begin
            halted <= 1'b1;
        end
    end

    assign bus.stall        = stall;
    assign bus.ex_valid     = idex.valid;
    assign bus.ex_pc_inc    = idex.pc_inc;
    assign bus.ex_op        = idex.op;
    assign bus.ex_rd        = idex.rd;
    assign bus.ex_src1      = idex.src1;
    assign bus.ex_src2      = idex.src2;
    assign bus.ex_rs_data   = idex.rs_data;
    assign bus.ex_rt_data   = idex.rt_data;
    assign bus.ex_imm       = idex.imm;
    assign bus.ex_cond      = idex.cond;
    assign bus.ex_reg_write = idex.ctrl.reg_write;
    assign bus.ex_mem_read  = idex.ctrl.mem_read;
    assign bus.ex_mem_write = idex.ctrl.mem_write;
    assign bus.ex_branch    = idex.ctrl.branch;
    assign bus.ex_call      = idex.ctrl.call;
    assign bus.ex_ret       = idex.ctrl.ret;
    assign bus.ex_halt      = idex.ctrl.halt;

endmodule

// File: tb/tb_id_slice.sv
// Directed scoreboard bench for id_slice: expected ID/EX bundles are queued
// as instructions are driven and popped one per clock edge.
module tb_id_slice;
    import cpu_pkg::*;

    localparam idex_t BUBBLE = '0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_slice_if bus ();

    id_slice #(.NOP_INSTR(16'hF000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    idex_t expQ[$];
    int    checkCount = 0;
    int    passCount  = 0;
    int    failCount  = 0;

    // Reference decode written straight from the instruction-set table.
    function automatic idex_t modelDecode(input logic [15:0] ins, input logic [15:0] pc,
                                          input logic [15:0] regA, input logic [15:0] regB);
        idex_t r;
        logic [3:0] o;
        r = '0;
        o = ins[15:12];
        r.valid  = 1'b1;
        r.pc_inc = pc;
        r.op     = o;
        r.cond   = ins[11:9];
        r.rd     = (o == 4'hD) ? 4'd15 : ins[11:8];
        if ((o == 4'hA) || (o == 4'hB)) r.src1 = ins[11:8];
        else if (o == 4'hE)             r.src1 = 4'd15;
        else                            r.src1 = ins[7:4];
        r.src2    = (o == 4'h9) ? ins[11:8] : ins[3:0];
        r.rs_data = (r.src1 == 4'd0) ? 16'h0000 : regA;
        r.rt_data = (r.src2 == 4'd0) ? 16'h0000 : regB;
        case (o)
            4'h7, 4'h8, 4'h9: r.imm = {{12{ins[3]}}, ins[3:0]};
            4'h4, 4'h5, 4'h6: r.imm = {12'h000, ins[3:0]};
            4'hA, 4'hB:       r.imm = {8'h00, ins[7:0]};
            4'hC:             r.imm = {{7{ins[8]}}, ins[8:0]};
            4'hD:             r.imm = {{4{ins[11]}}, ins[11:0]};
            default:          r.imm = 16'h0000;
        endcase
        r.ctrl.reg_write = ((o <= 4'h8) || (o == 4'hA) || (o == 4'hB) || (o == 4'hD)) && (r.rd != 4'd0);
        r.ctrl.mem_read  = (o == 4'h8);
        r.ctrl.mem_write = (o == 4'h9);
        r.ctrl.branch    = (o == 4'hC);
        r.ctrl.call      = (o == 4'hD);
        r.ctrl.ret       = (o == 4'hE);
        r.ctrl.halt      = (o == 4'hF);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] ins, input logic [15:0] pc);
        bus.instr  = ins;
        bus.PC_inc = pc;
    endtask

    task automatic setWb(input logic en, input logic [3:0] addr, input logic [15:0] data);
        bus.wb_en   = en;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic compareRecord(input string tag, input idex_t exp);
        idex_t obs;
        obs.valid          = bus.ex_valid;
        obs.pc_inc         = bus.ex_pc_inc;
        obs.op             = bus.ex_op;
        obs.rd             = bus.ex_rd;
        obs.src1           = bus.ex_src1;
        obs.src2           = bus.ex_src2;
        obs.rs_data        = bus.ex_rs_data;
        obs.rt_data        = bus.ex_rt_data;
        obs.imm            = bus.ex_imm;
        obs.cond           = bus.ex_cond;
        obs.ctrl.reg_write = bus.ex_reg_write;
        obs.ctrl.mem_read  = bus.ex_mem_read;
        obs.ctrl.mem_write = bus.ex_mem_write;
        obs.ctrl.branch    = bus.ex_branch;
        obs.ctrl.call      = bus.ex_call;
        obs.ctrl.ret       = bus.ex_ret;
        obs.ctrl.halt      = bus.ex_halt;
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: ID/EX observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL %s: no expected bundle queued", tag);
        end else begin
            compareRecord(tag, expQ.pop_front());
        end
    endtask

    task automatic checkStall(input logic exp, input string tag);
        checkCount++;
        assert (bus.stall === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: stall observed %b expected %b", tag, bus.stall, exp);
        end
    endtask

    task automatic step(input string tag);
        tick();
        checkOutput(tag);
    endtask

    initial begin
        $display("[TB] id_slice directed sequence");
        rst = 1'b1;
        bus.flush = 1'b0;
        setWb(1'b1, 4'd3, 16'hDEAD);
        applyStimulus(16'h0312, 16'h0100);
        tick();
        tick();
        compareRecord("reset_idex", BUBBLE);
        checkStall(1'b0, "reset_stall");

        // Preload R1=5, R2=7 while flushing so only bubbles flow.
        rst = 1'b0;
        bus.flush = 1'b1;
        setWb(1'b1, 4'd1, 16'd5);
        expQ.push_back(BUBBLE);
        step("preload_bubble1");
        setWb(1'b1, 4'd2, 16'd7);
        expQ.push_back(BUBBLE);
        step("preload_bubble2");

        // ADD R3,R1,R2
        bus.flush = 1'b0;
        setWb(1'b0, 4'd0, 16'h0000);
        applyStimulus(16'h0312, 16'h0101);
        expQ.push_back(BUBBLE);
        step("first_bubble");
        checkStall(1'b0, "add_nostall");

        // LW R4 then ADD R5,R4,R1: one stall, one bubble.
        applyStimulus(16'h8410, 16'h0102);
        expQ.push_back(modelDecode(16'h0312, 16'h0101, 16'd5, 16'd7));
        step("add_r3");
        applyStimulus(16'h0541, 16'h0103);
        expQ.push_back(modelDecode(16'h8410, 16'h0102, 16'd5, 16'h0000));
        step("lw_r4");
        checkStall(1'b1, "loaduse_port1");
        setWb(1'b1, 4'd4, 16'h0044);
        expQ.push_back(BUBBLE);
        step("loaduse_bubble");
        checkStall(1'b0, "loaduse_release");

        // LW R4 then LLB R6 (no R4 use), then LW R0 then use of R0.
        setWb(1'b0, 4'd0, 16'h0000);
        applyStimulus(16'h8410, 16'h0104);
        expQ.push_back(modelDecode(16'h0541, 16'h0103, 16'h0044, 16'd5));
        step("add_after_stall");
        applyStimulus(16'hB612, 16'h0105);
        expQ.push_back(modelDecode(16'h8410, 16'h0104, 16'd5, 16'h0000));
        step("lw_r4_again");
        checkStall(1'b0, "llb_nostall");
        applyStimulus(16'h8010, 16'h0106);
        expQ.push_back(modelDecode(16'hB612, 16'h0105, 16'h0000, 16'd7));
        step("llb_r6");
        applyStimulus(16'h0700, 16'h0107);
        expQ.push_back(modelDecode(16'h8010, 16'h0106, 16'd5, 16'h0000));
        step("lw_r0");
        checkStall(1'b0, "lw_r0_nostall");

        // Write to R0 during decode of ADD R7,R0,R0, then bypass on R2.
        setWb(1'b1, 4'd0, 16'h1234);
        applyStimulus(16'h0812, 16'h0108);
        expQ.push_back(modelDecode(16'h0700, 16'h0107, 16'h1234, 16'h1234));
        step("r0_reads_zero");
        setWb(1'b1, 4'd2, 16'hBEEF);
        applyStimulus(16'h8410, 16'h0109);
        expQ.push_back(modelDecode(16'h0812, 16'h0108, 16'd5, 16'hBEEF));
        step("bypass_r2");

        // LW R4 then SUB R5,R1,R4 (port-2 hazard), then flush beats stall.
        setWb(1'b0, 4'd0, 16'h0000);
        applyStimulus(16'h1514, 16'h010A);
        expQ.push_back(modelDecode(16'h8410, 16'h0109, 16'd5, 16'h0000));
        step("lw_r4_third");
        checkStall(1'b1, "loaduse_port2");
        bus.flush = 1'b1;
        #1;
        checkStall(1'b0, "flush_beats_stall");
        expQ.push_back(BUBBLE);
        step("flush_bubble");
        bus.flush = 1'b0;
        applyStimulus(16'hDFFF, 16'h0200);
        #1;
        checkStall(1'b0, "flush_clears");
        expQ.push_back(BUBBLE);
        step("post_flush_bubble");

        // CALL 0xFFF, B cond=5, HLT.
        applyStimulus(16'hCBF0, 16'h0201);
        expQ.push_back(modelDecode(16'hDFFF, 16'h0200, 16'h0000, 16'h0000));
        step("call_imm");
        applyStimulus(16'hF000, 16'h0202);
        expQ.push_back(modelDecode(16'hCBF0, 16'h0201, 16'h0000, 16'h0000));
        step("branch_cond");
        applyStimulus(16'h7111, 16'h0203);
        expQ.push_back(modelDecode(16'hF000, 16'h0202, 16'h0000, 16'h0000));
        step("hlt_enter");
        checkStall(1'b1, "halt_stall");
        for (int k = 0; k < 3; k++) begin
            expQ.push_back(BUBBLE);
            step("halt_bubble");
            checkStall(1'b1, "halt_sticky");
        end

        // Reset clears halt and the register file.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expQ.delete();
        compareRecord("reset2_idex", BUBBLE);
        checkStall(1'b0, "halt_cleared");
        applyStimulus(16'h0312, 16'h0300);
        expQ.push_back(BUBBLE);
        step("post_rst_bubble");
        expQ.push_back(modelDecode(16'h0312, 16'h0300, 16'h0000, 16'h0000));
        step("regs_cleared");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/id_slice.md
# id_slice

Instruction-decode stage of the 5-stage pipelined CPU, directly downstream of the fetch slice. Holds the IF/ID pipeline register, decodes the 16-bit instruction, and reads the 16x16 register file with write-through bypass from writeback. Detects load-use hazards and drives the fetch stall. Presents a registered ID/EX bundle to the execute stage.

## Interface
Parameters:
- NOP_INSTR, 16'hF000 — meaning: value loaded into IF/ID on reset or flush; decoded as a bubble while the valid bit is 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- PC_inc  in  16  PC+1 of the fetched instruction
- instr  in  16  fetched instruction
- flush  in  1  taken branch/call/ret resolved downstream; squash IF/ID and ID/EX
- wb_en  in  1  register-file write enable
- wb_addr  in  4  write address
- wb_data  in  16  write data
- stall  out  1  combinational; hold PC and IF/ID
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc_inc  out  16  PC+1 carried forward
- ex_op  out  4  opcode
- ex_rd  out  4  destination register
- ex_src1, ex_src2  out  4 each  source register numbers (for EX forwarding)
- ex_rs_data, ex_rt_data  out  16 each  read-port 1 / 2 data
- ex_imm  out  16  sign-/zero-extended immediate
- ex_cond  out  3  branch condition, instr[11:9]
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_call, ex_ret, ex_halt  out  1 each  control

## Operation
- Opcodes instr[15:12]: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 ADDI, 8 LW, 9 SW, A LHB, B LLB, C B, D CALL, E RET, F HLT. Fields: rd [11:8], rs [7:4], rt [3:0].
- Read port 1: rd for LHB/LLB, R15 for RET, else rs. Read port 2: rd for SW, else rt.
- Immediate: ADDI/LW/SW sext(instr[3:0]); shifts zext(instr[3:0]); LHB/LLB zext(instr[7:0]); B sext(instr[8:0]); CALL sext(instr[11:0]); others 0.
- ex_reg_write for ops 0-8, A, B, D (CALL writes R15: ex_rd=15). Never with ex_rd=0.
- Register file: R0 reads 0, writes to R0 ignored. Write-through: if wb_en and wb_addr==read address!=0, that port returns wb_data in the same cycle.
- Load-use: stall=1 when ID/EX holds a valid LW with ex_rd!=0 and the decoding valid instruction actually uses a read port whose address equals ex_rd. Port 1 is used by ops 0-9, A, B, E; port 2 by ops 0-3 and 9.
- On stall: IF/ID holds, ID/EX loads a bubble (ex_valid=0, all control 0).
- HLT: a sticky halted flag sets when HLT enters ID/EX; afterwards stall=1 permanently, bubbles issue; cleared only by rst.

## Timing
- Reset (rst high at an edge): IF/ID = NOP_INSTR, valid 0; every ex_* output 0; halted 0; stall 0; register file cleared to 0.
- Latency: instruction present on instr at edge N appears on ex_* after edge N+1.
- flush beats stall: IF/ID and ID/EX both become bubbles at the next edge; stall is forced 0 while flush=1.
- A stall lasts exactly 1 cycle per load-use pair, since the LW leaves ID/EX and the bubble breaks the match.
- A wb write and a read of the same register in the same cycle return the new data. A wb write during rst is ignored.

## Structure
- Package cpu_pkg: opcode localparams, NOP_INSTR, ID/EX control bundle struct, and a read-port-usage function.
- Sub-module regfile16: 16x16, two combinational read ports with bypass, one synchronous write port, synchronous reset.

## Test plan
- Reset then ADD R3,R1,R2 with R1=5, R2=7 preloaded via wb -> one cycle later ex_op=0, ex_rs_data=5, ex_rt_data=7, ex_rd=3, ex_reg_write=1.
- LW R4 followed by ADD R5,R4,R1 -> stall=1 for exactly one cycle, one bubble (ex_valid=0), then ADD issues.
- LW R4 followed by LLB R6,0x12 (no R4 use) -> no stall. LW R0 followed by use of R0 -> no stall.
- wb_en=1, wb_addr=2, wb_data=16'hBEEF in the same cycle that ADD reads R2 -> ex_rt_data=16'hBEEF. A write to R0 still reads 0.
- flush asserted while a LW/use stall is pending -> stall=0, both stages bubble next cycle.
- Decode coverage: CALL with offset 0xFFF gives ex_imm=16'hFFFF, ex_rd=15. B gives ex_cond=instr[11:9]. HLT gives permanent stall until rst.
